lsu_issue_queue: RTL and testbench

//  Parametrised synchronous LSU issue stage. Buffers decoded load/store instructions in a DEPTH-entry
//  in-order queue. For the head entry it fetches each source operand from the GRF or the bypass buffer
//  (chosen by its dependency tag), waits for all operands, then issues instruction+operands to EXE

---
 rtl/lsu_issue_queue.sv | 141 ++++++++++++++
 tb/tb_lsu_issue_queue.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_issue_queue.sv
// lsu_issue_queue: in-order LSU issue queue; resolves head operands from GRF/bypass, then issues to EXE.
module lsu_issue_queue #(
  parameter int INSN_W = 113,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEP_W  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [INSN_W-1:0]     enq_insn,
  input  logic [2*REG_W-1:0]    enq_rs,
  input  logic [2*DEP_W-1:0]    enq_dep,
  input  logic [DATA_W-1:0]     enq_imm,
  input  logic                  enq_use_imm,
  output logic [CNT_W-1:0]      count,
  output logic [1:0]            grf_req_valid,
  input  logic [1:0]            grf_req_ready,
  output logic [2*REG_W-1:0]    grf_req_addr,
  input  logic [1:0]            grf_rsp_valid,
  input  logic [2*DATA_W-1:0]   grf_rsp_data,
  output logic [1:0]            byp_req_valid,
  input  logic [1:0]            byp_req_ready,
  output logic [2*DEP_W-1:0]    byp_req_tag,
  input  logic [1:0]            byp_rsp_valid,
  input  logic [2*DATA_W-1:0]   byp_rsp_data,
  output logic                  exe_valid,
  input  logic                  exe_ready,
  output logic [INSN_W-1:0]     exe_insn,
  output logic [DATA_W-1:0]     exe_op1,
  output logic [DATA_W-1:0]     exe_op2
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [DEP_W-1:0] NO_DEP = '1;
  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} stateT;
  stateT state;
  logic [INSN_W-1:0] insnMem [DEPTH];
  logic [2*REG_W-1:0] rsMem [DEPTH];
  logic [2*DEP_W-1:0] depMem [DEPTH];
  logic [DATA_W-1:0] immMem [DEPTH];
  logic [DEPTH-1:0] useImmMem;
  logic [PW:0] wrPtr, rdPtr;
  logic push, pop, ld, fromEnq, ldUseImm;
  logic [PW-1:0] headIdx;
  logic [2*REG_W-1:0] ldRs, opRs;
  logic [2*DEP_W-1:0] ldDep, opDep;
  logic [DATA_W-1:0] ldImm;
  logic [1:0] reqV, waitRsp, done, isByp, reqHs, rspV;
  logic [1:0][DATA_W-1:0] opData, rspD;
  assign count = CNT_W'(wrPtr - rdPtr);
  assign enq_ready = count != CNT_W'(DEPTH);
  assign push = enq_valid & enq_ready;
  assign pop = exe_valid & exe_ready;
  assign ld = (state == IDLE && count != '0) || (pop && (count > CNT_W'(1) || push));
  // On a pop the next head is the following slot, or the entry being pushed right now if the queue drains to it.
  assign fromEnq = state == ISSUE && count == CNT_W'(1);
  assign headIdx = state == ISSUE ? rdPtr[PW-1:0] + PW'(1) : rdPtr[PW-1:0];
  assign ldRs = fromEnq ? enq_rs : rsMem[headIdx];
  assign ldDep = fromEnq ? enq_dep : depMem[headIdx];
  assign ldImm = fromEnq ? enq_imm : immMem[headIdx];
  assign ldUseImm = fromEnq ? enq_use_imm : useImmMem[headIdx];
  assign grf_req_valid = reqV & ~isByp;
  assign byp_req_valid = reqV & isByp;
  assign grf_req_addr = opRs;
  assign byp_req_tag = opDep;
  for (genvar i = 0; i < 2; i++) begin : gOp
    assign reqHs[i] = reqV[i] & (isByp[i] ? byp_req_ready[i] : grf_req_ready[i]);
    assign rspV[i] = isByp[i] ? byp_rsp_valid[i] : grf_rsp_valid[i];
    assign rspD[i] = isByp[i] ? byp_rsp_data[i*DATA_W +: DATA_W] : grf_rsp_data[i*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk) begin
    if (push) begin
      insnMem[wrPtr[PW-1:0]] <= enq_insn;
      rsMem[wrPtr[PW-1:0]] <= enq_rs;
      depMem[wrPtr[PW-1:0]] <= enq_dep;
      immMem[wrPtr[PW-1:0]] <= enq_imm;
      useImmMem[wrPtr[PW-1:0]] <= enq_use_imm;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wrPtr <= '0;
      rdPtr <= '0;
      reqV <= '0;
      waitRsp <= '0;
      done <= '0;
      isByp <= '0;
      opData <= '0;
      opRs <= '0;
      opDep <= '0;
      exe_valid <= 1'b0;
      exe_insn <= '0;
      exe_op1 <= '0;
      exe_op2 <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + (PW+1)'(1);
      if (pop) begin
        rdPtr <= rdPtr + (PW+1)'(1);
        exe_valid <= 1'b0;
      end
      if (ld) begin
        state <= COLLECT;
        opRs <= ldRs;
        opDep <= ldDep;
        reqV <= {~ldUseImm, 1'b1};
        isByp <= {ldDep[DEP_W +: DEP_W] != NO_DEP && !ldUseImm, ldDep[DEP_W-1:0] != NO_DEP};
        done <= {ldUseImm, 1'b0};
        waitRsp <= '0;
        opData <= {ldImm, DATA_W'(0)};
      end else if (pop) begin
        state <= IDLE;
        done <= '0;
      end else if (state == COLLECT) begin
        if (&done) begin
          state <= ISSUE;
          exe_valid <= 1'b1;
          exe_insn <= insnMem[rdPtr[PW-1:0]];
          exe_op1 <= opData[0];
          exe_op2 <= opData[1];
        end
        for (int i = 0; i < 2; i++) begin
          if (reqHs[i]) begin
            reqV[i] <= 1'b0;
            if (rspV[i]) begin
              opData[i] <= rspD[i];
              done[i] <= 1'b1;
            end else waitRsp[i] <= 1'b1;
          end else if (waitRsp[i] && rspV[i]) begin
            opData[i] <= rspD[i];
            done[i] <= 1'b1;
            waitRsp[i] <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_lsu_issue_queue.sv
// tb_lsu_issue_queue: directed stimulus against a queue-level reference model with fixed GRF/bypass responders.
module tb_lsu_issue_queue;
  logic clk = 0, rst = 1;
  logic enq_valid = 0, enq_ready, enq_use_imm = 0, exe_valid, exe_ready = 0;
  logic [112:0] enq_insn = '0, exe_insn;
  logic [9:0] enq_rs = '0, grf_req_addr;
  logic [7:0] enq_dep = '0, byp_req_tag;
  logic [31:0] enq_imm = '0, exe_op1, exe_op2;
  logic [4:0] count;
  logic [1:0] grf_req_valid, grf_req_ready, grf_rsp_valid, byp_req_valid, byp_req_ready, byp_rsp_valid;
  logic [63:0] grf_rsp_data, byp_rsp_data;
  logic grfRdy = 1, bypRdy = 1, delayMode = 0, noiseEn = 0;
  logic [1:0] gPend = '0, bPend = '0;
  int nTests = 0, nFail = 0;

  typedef struct packed {
    logic [112:0] insn;
    logic [4:0] rs1, rs2;
    logic [3:0] d1, d2;
    logic ui;
    logic [31:0] imm;
  } entT;
  entT q[$];

  lsu_issue_queue dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_insn(enq_insn),
    .enq_rs(enq_rs), .enq_dep(enq_dep), .enq_imm(enq_imm), .enq_use_imm(enq_use_imm), .count(count),
    .grf_req_valid(grf_req_valid), .grf_req_ready(grf_req_ready), .grf_req_addr(grf_req_addr),
    .grf_rsp_valid(grf_rsp_valid), .grf_rsp_data(grf_rsp_data),
    .byp_req_valid(byp_req_valid), .byp_req_ready(byp_req_ready), .byp_req_tag(byp_req_tag),
    .byp_rsp_valid(byp_rsp_valid), .byp_rsp_data(byp_rsp_data),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_insn(exe_insn), .exe_op1(exe_op1), .exe_op2(exe_op2)
  );

  always #5 clk = ~clk;

  // GRF returns 17*index, bypass returns 0xB000+tag; spurious responses carry 0xDEAD and must be ignored.
  assign grf_req_ready = {2{grfRdy}};
  assign byp_req_ready = {2{bypRdy}};
  always @(posedge clk) begin
    gPend <= grf_req_valid & {2{grfRdy}};
    bPend <= byp_req_valid & {2{bypRdy}};
  end
  for (genvar g = 0; g < 2; g++) begin : gRsp
    logic gReal, bReal;
    assign gReal = delayMode ? gPend[g] : grf_req_valid[g] & grfRdy;
    assign bReal = delayMode ? bPend[g] : byp_req_valid[g] & bypRdy;
    assign grf_rsp_valid[g] = gReal | (noiseEn & ((grf_req_valid[g] & ~grfRdy) | byp_req_valid[g]));
    assign byp_rsp_valid[g] = bReal | (noiseEn & ((byp_req_valid[g] & ~bypRdy) | grf_req_valid[g]));
    assign grf_rsp_data[g*32 +: 32] = gReal ? 32'(grf_req_addr[g*5 +: 5]) * 32'd17 : 32'hDEAD;
    assign byp_rsp_data[g*32 +: 32] = bReal ? 32'hB000 + 32'(byp_req_tag[g*4 +: 4]) : 32'hDEAD;
  end

  task automatic chk(input string nm, input bit [127:0] act, input bit [127:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] expOp(entT e, int i);
    if (i == 0) return e.d1 == 4'hF ? 32'(e.rs1) * 32'd17 : 32'hB000 + 32'(e.d1);
    return e.ui ? e.imm : (e.d2 == 4'hF ? 32'(e.rs2) * 32'd17 : 32'hB000 + 32'(e.d2));
  endfunction

  // Reference model: in-order queue, head operand routing, issue contents and stall stability.
  logic stallPrev = 0;
  logic [112:0] pInsn;
  logic [31:0] pOp1, pOp2;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stallPrev = 0;
    end else begin
      entT h, n;
      logic [1:0] eg, eb;
      chk("count", 128'(count), 128'(q.size()));
      chk("enq_ready", 128'(enq_ready), 128'(q.size() != 16));
      if (q.size() == 0) begin
        chk("idle_exe_valid", 128'(exe_valid), 128'(0));
        chk("idle_reqs", 128'({grf_req_valid, byp_req_valid}), 128'(0));
      end else begin
        h = q[0];
        if (exe_valid) begin
          chk("issue_reqs", 128'({grf_req_valid, byp_req_valid}), 128'(0));
          chk("exe_insn", 128'(exe_insn), 128'(h.insn));
          chk("exe_op1", 128'(exe_op1), 128'(expOp(h, 0)));
          chk("exe_op2", 128'(exe_op2), 128'(expOp(h, 1)));
        end else begin
          eg = {!h.ui && h.d2 == 4'hF, h.d1 == 4'hF};
          eb = {!h.ui && h.d2 != 4'hF, h.d1 != 4'hF};
          chk("grf_req_route", 128'(grf_req_valid & ~eg), 128'(0));
          chk("byp_req_route", 128'(byp_req_valid & ~eb), 128'(0));
          if (grf_req_valid != 0) chk("grf_req_addr", 128'(grf_req_addr), 128'({h.rs2, h.rs1}));
          if (byp_req_valid != 0) chk("byp_req_tag", 128'(byp_req_tag), 128'({h.d2, h.d1}));
        end
      end
      if (stallPrev) begin
        chk("stall_valid", 128'(exe_valid), 128'(1));
        chk("stall_data", 128'({exe_insn, exe_op1, exe_op2}) ^ 128'({pInsn, pOp1, pOp2}), 128'(0));
      end
      stallPrev = exe_valid & !exe_ready;
      pInsn = exe_insn;
      pOp1 = exe_op1;
      pOp2 = exe_op2;
      if (exe_valid && exe_ready && q.size() > 0) void'(q.pop_front());
      if (enq_valid && enq_ready) begin
        n.insn = enq_insn;
        {n.rs2, n.rs1} = enq_rs;
        {n.d2, n.d1} = enq_dep;
        n.ui = enq_use_imm;
        n.imm = enq_imm;
        q.push_back(n);
      end
    end
  end

  task automatic setEnq(input logic [112:0] insn, input logic [4:0] r2, input logic [4:0] r1,
                        input logic [3:0] d2, input logic [3:0] d1, input logic ui, input logic [31:0] im);
    enq_insn = insn;
    enq_rs = {r2, r1};
    enq_dep = {d2, d1};
    enq_use_imm = ui;
    enq_imm = im;
  endtask

  task automatic push(input logic [112:0] insn, input logic [4:0] r2, input logic [4:0] r1,
                      input logic [3:0] d2, input logic [3:0] d1, input logic ui, input logic [31:0] im);
    bit ok;
    ok = 0;
    setEnq(insn, r2, r1, d2, d1, ui, im);
    enq_valid = 1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (enq_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("enq_timeout", 128'(0), 128'(1));
    @(posedge clk);
    #1 enq_valid = 0;
  endtask

  task automatic waitExe();
    bit ok;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exe_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("exe_timeout", 128'(0), 128'(1));
  endtask

  task automatic waitEmpty();
    bit ok;
    ok = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (count == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 128'(0), 128'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_exe", 128'({exe_valid, exe_op1, exe_op2}), 128'(0));
    chk("rst_reqs", 128'({grf_req_valid, byp_req_valid}), 128'(0));
    @(posedge clk);
    #1 rst = 0;
    exe_ready = 1;
    // T2: GRF path with latency N+2 request, N+4 issue
    push(113'd1, 5'd2, 5'd1, 4'hF, 4'hF, 1'b0, 32'd0);
    @(negedge clk) chk("t2_n1_req", 128'(grf_req_valid), 128'(0));
    @(negedge clk) chk("t2_n2_req", 128'(grf_req_valid), 128'(2'b11));
    chk("t2_addr", 128'(grf_req_addr), 128'(10'h041));
    @(negedge clk) chk("t2_n3_exe", 128'(exe_valid), 128'(0));
    @(negedge clk) chk("t2_n4_exe", 128'(exe_valid), 128'(1));
    chk("t2_op1", 128'(exe_op1), 128'(32'h11));
    chk("t2_op2", 128'(exe_op2), 128'(32'h22));
    @(posedge clk);
    #1;
    // T3: bypass op1, immediate op2
    push(113'd2, 5'd7, 5'd0, 4'hF, 4'h3, 1'b1, 32'h40);
    @(negedge clk);
    @(negedge clk) chk("t3_byp_req", 128'(byp_req_valid), 128'(2'b01));
    chk("t3_grf_req", 128'(grf_req_valid), 128'(0));
    chk("t3_tag", 128'(byp_req_tag[3:0]), 128'(3));
    @(negedge clk);
    @(negedge clk) chk("t3_exe", 128'(exe_valid), 128'(1));
    chk("t3_op1", 128'(exe_op1), 128'(32'hB003));
    chk("t3_op2", 128'(exe_op2), 128'(32'h40));
    @(posedge clk);
    #1;
    // T5: EXE backpressure for 5 cycles
    exe_ready = 0;
    push(113'd3, 5'd4, 5'd5, 4'hF, 4'hF, 1'b0, 32'd0);
    waitExe();
    chk("t5_op1", 128'(exe_op1), 128'(32'h55));
    chk("t5_op2", 128'(exe_op2), 128'(32'h44));
    repeat (5) begin
      @(negedge clk);
      chk("t5_count", 128'(count), 128'(1));
      chk("t5_hold", 128'({exe_valid, exe_op1}), 128'({1'b1, 32'h55}));
    end
    @(posedge clk);
    #1 exe_ready = 1;
    waitEmpty();
    // Delayed responses, slow GRF, and spurious responses that must be ignored
    delayMode = 1;
    noiseEn = 1;
    grfRdy = 0;
    push(113'd7, 5'd9, 5'd6, 4'hF, 4'h2, 1'b0, 32'd0);
    repeat (4) @(posedge clk);
    #1 grfRdy = 1;
    waitExe();
    chk("dly_op1", 128'(exe_op1), 128'(32'hB002));
    chk("dly_op2", 128'(exe_op2), 128'(32'h99));
    waitEmpty();
    delayMode = 0;
    noiseEn = 0;
    // T4: fill to 16, hold full, then 40 pushes through the wrapping queue
    exe_ready = 0;
    for (int k = 0; k < 16; k++)
      push(113'(k + 16'h100), 5'(~k), 5'(k), (k % 4 == 1) ? 4'h5 : 4'hF,
           (k % 3 == 0) ? 4'(k % 15) : 4'hF, k % 5 == 0, 32'(k * 257));
    @(negedge clk) chk("t4_full_count", 128'(count), 128'(16));
    chk("t4_full_ready", 128'(enq_ready), 128'(0));
    waitExe();
    @(posedge clk);
    #1 exe_ready = 1;
    for (int k = 16; k < 56; k++)
      push(113'(k + 16'h100), 5'(~k), 5'(k), (k % 4 == 1) ? 4'h5 : 4'hF,
           (k % 3 == 0) ? 4'(k % 15) : 4'hF, k % 5 == 0, 32'(k * 257));
    waitEmpty();
    // T6: pop and push in the same cycle with one entry
    exe_ready = 0;
    push(113'd100, 5'd1, 5'd2, 4'hF, 4'hF, 1'b0, 32'd0);
    waitExe();
    @(posedge clk);
    #1 setEnq(113'd101, 5'd3, 5'd8, 4'hF, 4'hF, 1'b0, 32'd0);
    enq_valid = 1;
    exe_ready = 1;
    @(negedge clk) chk("t6_count_before", 128'(count), 128'(1));
    @(posedge clk);
    #1 enq_valid = 0;
    @(negedge clk) chk("t6_count_after", 128'(count), 128'(1));
    chk("t6_new_req", 128'(grf_req_valid), 128'(2'b11));
    chk("t6_new_addr", 128'(grf_req_addr), 128'({5'd3, 5'd8}));
    waitExe();
    waitEmpty();
    // T1: reset while requests are pending
    grfRdy = 0;
    push(113'd200, 5'd1, 5'd1, 4'hF, 4'hF, 1'b0, 32'd0);
    push(113'd201, 5'd2, 5'd2, 4'hF, 4'hF, 1'b0, 32'd0);
    @(negedge clk) chk("t1_stuck_req", 128'(grf_req_valid), 128'(2'b11));
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk) chk("t1_count", 128'(count), 128'(0));
    chk("t1_exe", 128'(exe_valid), 128'(0));
    chk("t1_reqs", 128'({grf_req_valid, byp_req_valid}), 128'(0));
    @(posedge clk);
    #1 rst = 0;
    grfRdy = 1;
    @(negedge clk) chk("t1_enq_ready", 128'(enq_ready), 128'(1));
    chk("t1_count_after", 128'(count), 128'(0));
    @(posedge clk);
    #1 push(113'd202, 5'd6, 5'd3, 4'hF, 4'hF, 1'b0, 32'd0);
    waitExe();
    chk("t1_recover_op1", 128'(exe_op1), 128'(32'h33));
    waitEmpty();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
